controlador_botoes: RTL

Multi-channel, parametrised push-button front end that replaces single-button debouncing across the Tamagotchi control panel. Each channel synchronises an asynchronous active-low button pin and debounces it with a per-channel counter. It produces a clean pressed level plus single-cycle press, release, long-press (hold) and auto-repeat event pulses. It sits between the board button pins and the game FSM / menu logic, all in the single system clock domain.

---
 rtl/controlador_botoes.sv | 130 +++++++++++++
 1 files changed

// File: rtl/controlador_botoes.sv
// controlador_botoes: multi-channel push-button front end.
//
// Each channel synchronises an asynchronous active-low button pin, debounces it and derives
// single-cycle press / release / long-press (hold) / auto-repeat event pulses.
//
// Parameters:
//   N             number of independent channels (>= 1)
//   DEB_CYCLES    consecutive disagreeing samples needed to accept a new level (>= 2)
//   HOLD_CYCLES   cycles from press_pulse to hold_pulse (>= 1)
//   REPEAT_CYCLES auto-repeat period after hold_pulse; 0 disables repeat
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   b_in          raw button pins, active-low (0 = pressed)
//   pressed       debounced level, 1 = pressed
//   press_pulse   one-cycle pulse on an accepted press
//   release_pulse one-cycle pulse on an accepted release
//   hold_pulse    one-cycle pulse after HOLD_CYCLES of continuous press
//   rep_pulse     one-cycle auto-repeat pulses while held past hold
module controlador_botoes #(
   parameter int unsigned N             = 4,
   parameter int unsigned DEB_CYCLES    = 16,
   parameter int unsigned HOLD_CYCLES   = 25_000_000,
   parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] b_in,
   output logic [N-1:0] pressed,
   output logic [N-1:0] press_pulse,
   output logic [N-1:0] release_pulse,
   output logic [N-1:0] hold_pulse,
   output logic [N-1:0] rep_pulse
);

   localparam int unsigned DW   = $clog2(DEB_CYCLES);
   localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned HW   = $clog2(HMAX + 1);

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   // Only meaningful when REPEAT_CYCLES > 0; the repeat branch is disabled otherwise.
   localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

   typedef enum logic {PhWaitHold, PhRepeat} phase_e;

   for (genvar g = 0; g < N; g++) begin : g_chan
      logic          sync1_q;
      logic          sync2_q;
      logic          raw;
      logic          accept;
      logic [DW-1:0] deb_cnt_q;
      logic [HW-1:0] hold_cnt_q;
      phase_e        phase_q;
      logic          pressed_q;
      logic          press_q;
      logic          release_q;
      logic          hold_q;
      logic          rep_q;

      assign raw    = ~sync2_q;
      // New level accepted on this edge.
      assign accept = (raw != pressed_q) && (deb_cnt_q == DEB_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            phase_q    <= PhWaitHold;
            pressed_q  <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            hold_q     <= 1'b0;
            rep_q      <= 1'b0;
         end else begin
            sync1_q   <= b_in[g];
            sync2_q   <= sync1_q;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= 1'b0;
            rep_q     <= 1'b0;

            // Debounce: any agreeing sample restarts the count.
            if (raw == pressed_q) begin
               deb_cnt_q <= '0;
            end else if (accept) begin
               deb_cnt_q <= '0;
               pressed_q <= raw;
               press_q   <= raw;
               release_q <= ~raw;
            end else begin
               deb_cnt_q <= deb_cnt_q + DW'(1);
            end

            // Hold / repeat; a release accepted on this edge overrides any expiring count.
            if (!pressed_q || accept) begin
               hold_cnt_q <= '0;
               phase_q    <= PhWaitHold;
            end else if (phase_q == PhWaitHold) begin
               if (hold_cnt_q == HOLD_LAST) begin
                  hold_q     <= 1'b1;
                  hold_cnt_q <= '0;
                  phase_q    <= PhRepeat;
               end else begin
                  hold_cnt_q <= hold_cnt_q + HW'(1);
               end
            end else if (REPEAT_CYCLES != 0) begin
               if (hold_cnt_q == REP_LAST) begin
                  rep_q      <= 1'b1;
                  hold_cnt_q <= '0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + HW'(1);
               end
            end else begin
               hold_cnt_q <= '0;
            end
         end
      end

      assign pressed[g]       = pressed_q;
      assign press_pulse[g]   = press_q;
      assign release_pulse[g] = release_q;
      assign hold_pulse[g]    = hold_q;
      assign rep_pulse[g]     = rep_q;
   end

endmodule
